// File: rtl/mux_nx1_scan_if.sv
// mux_nx1_scan_if: data, select and status bundle for the scanning channel mux
interface mux_nx1_scan_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [CHANNELS*WIDTH-1:0] D;
  logic [SEL_W-1:0]          S;
  logic                      MODE;
  logic                      EN;
  logic [WIDTH-1:0]          X;
  logic [SEL_W-1:0]          CH;
  logic                      VALID;
  logic                      ERR;
  modport master (output D, S, MODE, EN, input X, CH, VALID, ERR);
  modport slave  (input D, S, MODE, EN, output X, CH, VALID, ERR);
endinterface

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N-channel mux with manual select or round-robin dwell scan
module mux_nx1_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input logic           clk,
  input logic           rst,
  mux_nx1_scan_if.slave bus
);
  localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int PAD   = 2 ** SEL_W;
  logic [WIDTH-1:0]     x_q, x_d, sel_data;
  logic [SEL_W-1:0]     ch_q, ch_d, ptr_q, ptr_d, sel;
  logic [7:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d, err_q, err_d, in_range, dwell_done;
  logic [PAD*WIDTH-1:0] d_pad;
  // zero-padding to a power-of-two channel count keeps out-of-range selects inside the vector
  assign d_pad      = (PAD*WIDTH)'(bus.D);
  assign sel        = bus.MODE ? ptr_q : bus.S;
  assign sel_data   = d_pad[int'(sel)*WIDTH +: WIDTH];
  assign in_range   = int'(bus.S) < CHANNELS;
  assign dwell_done = cnt_q == 8'(DWELL - 1);
  // next state; in manual mode ptr shadows CH so a switch to scan resumes on the shown channel
  always_comb begin
    x_d     = x_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (bus.EN && bus.MODE) begin
      x_d     = sel_data;
      ch_d    = ptr_q;
      valid_d = 1'b1;
      cnt_d   = dwell_done ? 8'd0 : cnt_q + 8'd1;
      ptr_d   = !dwell_done ? ptr_q : ptr_q == SEL_W'(CHANNELS - 1) ? '0 : ptr_q + 1'b1;
    end else if (bus.EN) begin
      cnt_d   = 8'd0;
      x_d     = in_range ? sel_data : x_q;
      ch_d    = in_range ? bus.S : ch_q;
      ptr_d   = in_range ? bus.S : ch_q;
      valid_d = in_range;
      err_d   = err_q | !in_range;
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      ptr_q   <= '0;
    end else begin
      x_q     <= x_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end
  assign bus.X     = x_q;
  assign bus.CH    = ch_q;
  assign bus.VALID = valid_q;
  assign bus.ERR   = err_q;
endmodule
